// File: rtl/trena_pkg.sv
// Shared types and constants for the tape-measure sequencer: state codes,
// ASCII characters sent over serial, and the BCD-to-ASCII helper.
package trena_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    OCIOSO         = 4'h1,
    DISPARA        = 4'h2,
    AGUARDA_MEDIDA = 4'h3,
    PREPARA        = 4'h4,
    TRANSMITE      = 4'h5,
    AGUARDA_TX     = 4'h6,
    FIM            = 4'h7
  } estado_t;

  localparam logic [6:0] ASC_ZERO     = 7'h30;
  localparam logic [6:0] ASC_INVALIDO = 7'h3F;
  localparam logic [6:0] ASC_TRACO    = 7'h2D;
  localparam logic [6:0] ASC_FIM      = 7'h23;

  localparam int IDX_W = 2;

  // Non-decimal BCD codes are shown as '?' so a bad sensor reading is visible.
  function automatic logic [6:0] ascii_digito(input logic [3:0] d);
    if (d > 4'd9) begin
      return ASC_INVALIDO;
    end
    return ASC_ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear and enable; fim flags the terminal
// count M-1. Clear has priority over count.
module contador_m #(
  parameter int M = 100,
  parameter int N = $clog2(M)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         fim
);

  localparam logic [N-1:0] MAXV = N'(M - 1);

  logic [N-1:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (zera) begin
      cont_d = '0;
    end else if (conta) begin
      cont_d = (cont_q == MAXV) ? '0 : cont_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign Q   = cont_q;
  assign fim = (cont_q == MAXV);

endmodule

// File: rtl/trena_sequenciador.sv
// Measurement sequencer: triggers the sonar (manual or periodic), guards the echo
// with a timeout, then sends three ASCII digits plus a terminator, one per tx_pronto.
module trena_sequenciador
  import trena_pkg::*;
#(
  parameter int         PERIODO_AUTO = 25_000_000,
  parameter int         TIMEOUT      = 2_000_000,
  parameter logic [6:0] CHAR_FIM     = ASC_FIM
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mensurar,
  input  logic       modo_auto,
  output logic       medir,
  input  logic       medida_pronto,
  input  logic [3:0] medida2,
  input  logic [3:0] medida1,
  input  logic [3:0] medida0,
  output logic       tx_partida,
  output logic [6:0] tx_dado,
  input  logic       tx_pronto,
  output logic       pronto,
  output logic       erro_timeout,
  output logic [3:0] db_estado
);

  localparam int NA = $clog2(PERIODO_AUTO);
  localparam int NT = $clog2(TIMEOUT);

  estado_t              estado_q, estado_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 erro_q, erro_d;
  logic [2:0][6:0]      car_q, car_d;
  logic [6:0]           tx_dado_q, tx_dado_d;
  logic [6:0]           char_sel;

  logic [NA-1:0]        auto_q;
  logic                 auto_fim, auto_conta, auto_zera, auto_tick;
  logic [NT-1:0]        tmo_q;
  logic                 tmo_fim, tmo_conta;

  // The period only elapses while idle in auto mode; FIM restarts it so the
  // spacing is measured from the end of each cycle.
  assign auto_conta = modo_auto && (estado_q == OCIOSO);
  assign auto_tick  = auto_conta && auto_fim;
  assign auto_zera  = !modo_auto || (estado_q == FIM) || auto_tick;

  contador_m #(.M(PERIODO_AUTO), .N(NA)) u_auto (
    .clock (clock),
    .reset (reset),
    .zera  (auto_zera),
    .conta (auto_conta),
    .Q     (auto_q),
    .fim   (auto_fim)
  );

  assign tmo_conta = (estado_q == AGUARDA_MEDIDA);

  contador_m #(.M(TIMEOUT), .N(NT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (!tmo_conta),
    .conta (tmo_conta),
    .Q     (tmo_q),
    .fim   (tmo_fim)
  );

  logic unused_contadores;
  assign unused_contadores = ^{auto_q, tmo_q};

  always_comb begin
    estado_d   = estado_q;
    idx_d      = idx_q;
    erro_d     = erro_q;
    car_d      = car_q;
    medir      = 1'b0;
    tx_partida = 1'b0;
    pronto     = 1'b0;
    case (estado_q)
      INICIAL: estado_d = OCIOSO;
      OCIOSO: begin
        if (mensurar || auto_tick) begin
          estado_d = DISPARA;
        end
      end
      DISPARA: begin
        medir    = 1'b1;
        erro_d   = 1'b0;
        estado_d = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA: begin
        // A reading arriving on the terminal count still counts as valid.
        if (medida_pronto) begin
          car_d[2] = ascii_digito(medida2);
          car_d[1] = ascii_digito(medida1);
          car_d[0] = ascii_digito(medida0);
          estado_d = PREPARA;
        end else if (tmo_fim) begin
          erro_d   = 1'b1;
          car_d    = {3{ASC_TRACO}};
          estado_d = PREPARA;
        end
      end
      PREPARA: begin
        idx_d    = '0;
        estado_d = TRANSMITE;
      end
      TRANSMITE: begin
        tx_partida = 1'b1;
        estado_d   = AGUARDA_TX;
      end
      AGUARDA_TX: begin
        if (tx_pronto) begin
          if (idx_q == IDX_W'(3)) begin
            estado_d = FIM;
          end else begin
            idx_d    = idx_q + 1'b1;
            estado_d = TRANSMITE;
          end
        end
      end
      FIM: begin
        pronto   = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_comb begin
    char_sel = CHAR_FIM;
    case (idx_d)
      2'd0:    char_sel = car_q[2];
      2'd1:    char_sel = car_q[1];
      2'd2:    char_sel = car_q[0];
      default: char_sel = CHAR_FIM;
    endcase
  end

  // Character is captured on entry to TRANSMITE and held until the next one.
  always_comb begin
    tx_dado_d = tx_dado_q;
    if ((estado_d == TRANSMITE) && (estado_q != TRANSMITE)) begin
      tx_dado_d = char_sel;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      idx_q     <= '0;
      erro_q    <= 1'b0;
      car_q     <= '0;
      tx_dado_q <= '0;
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      erro_q    <= erro_d;
      car_q     <= car_d;
      tx_dado_q <= tx_dado_d;
    end
  end

  assign tx_dado      = tx_dado_q;
  assign erro_timeout = erro_q;
  assign db_estado    = estado_q;

endmodule
